// File: rtl/sys_bus_arbiter_pkg.sv
// Shared bus encodings and arbiter state encoding used by the sys_bus arbiter
// and anything else that drives or observes sys_bus control codes.
package rvcpu_bus_defs;

  typedef enum logic [2:0] {
    RD_NONE = 3'd0,
    RD_LB   = 3'd1,
    RD_LH   = 3'd2,
    RD_LW   = 3'd3,
    RD_LD   = 3'd4,
    RD_LBU  = 3'd5,
    RD_LHU  = 3'd6,
    RD_LWU  = 3'd7
  } bus_rd_e;

  typedef enum logic [2:0] {
    WR_NONE = 3'd0,
    WR_SB   = 3'd1,
    WR_SH   = 3'd2,
    WR_SW   = 3'd3,
    WR_SD   = 3'd4
  } bus_wr_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_IF  = 2'd1,
    GNT_MEM = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sys_bus_arbiter_if.sv
// Stage-port and sys_bus signal bundle for the arbiter. The slave modport is
// the arbiter's view; the master modport is the pipeline-plus-bus view.
interface sys_bus_arbiter_if;
  // Handshake: a port raises *_req with a stable payload and holds it until
  // it sees a one-cycle *_ack; rdata is valid only while *_ack is high.
  // On the bus side bus_* hold steady for the whole grant until bus_ready.
  logic        if_req;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        if_stall;

  logic        mem_req;
  logic [2:0]  mem_rd_ctrl;
  logic [2:0]  mem_wr_ctrl;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ack;
  logic        mem_stall;

  logic [2:0]  bus_rd_ctrl;
  logic [2:0]  bus_wr_ctrl;
  logic [63:0] bus_addr;
  logic [63:0] bus_din;
  logic [63:0] bus_dout;
  logic        bus_ready;
  logic        timeout_err;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_ack, if_stall,
    input  mem_req, mem_rd_ctrl, mem_wr_ctrl, mem_addr, mem_wdata,
    output mem_rdata, mem_ack, mem_stall,
    output bus_rd_ctrl, bus_wr_ctrl, bus_addr, bus_din,
    input  bus_dout, bus_ready,
    output timeout_err
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_ack, if_stall,
    output mem_req, mem_rd_ctrl, mem_wr_ctrl, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack, mem_stall,
    input  bus_rd_ctrl, bus_wr_ctrl, bus_addr, bus_din,
    output bus_dout, bus_ready,
    input  timeout_err
  );
endinterface

// File: rtl/sys_bus_arbiter.sv
// Registered two-port arbiter for sys_bus: MEM-priority grant FSM with an IF
// starvation guard, per-port req/ack handshake, stalls and a dead-slave timeout.
module sys_bus_arbiter
  import rvcpu_bus_defs::*;
#(
  parameter int         FAIR_LIMIT = 2,
  parameter int         TIMEOUT    = 16,
  parameter logic [2:0] IF_RD_CTRL = 3'b011
) (
  input  logic             clk,
  input  logic             rst,
  sys_bus_arbiter_if.slave bif,
  output arb_state_e       o_state
);

  localparam int SW = $clog2(FAIR_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(FAIR_LIMIT);
  localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT);

  arb_state_e  r_state;
  arb_state_e  w_next_state;
  logic [SW-1:0] r_starve_cnt;
  logic [TW-1:0] r_tmo_cnt;
  logic        r_if_ack;
  logic        r_mem_ack;
  logic        r_timeout_err;
  logic [31:0] r_if_rdata;
  logic [63:0] r_mem_rdata;
  logic [2:0]  r_bus_rd_ctrl;
  logic [2:0]  r_bus_wr_ctrl;
  logic [63:0] r_bus_addr;
  logic [63:0] r_bus_din;

  logic w_if_valid;
  logic w_mem_valid;
  logic w_turnaround;
  logic w_pick_if;
  logic w_pick_mem;
  logic w_done;
  logic w_abort;

  // The ack cycle is a turnaround: nobody is granted, so a requester still
  // holding its (already served) request is never re-granted on stale data.
  assign w_turnaround = r_if_ack || r_mem_ack;
  assign w_if_valid   = bif.if_req  && !r_if_ack;
  assign w_mem_valid  = bif.mem_req && !r_mem_ack;

  always_comb begin
    w_next_state = r_state;
    w_pick_if    = 1'b0;
    w_pick_mem   = 1'b0;
    w_done       = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_turnaround) begin
          if (w_if_valid && w_mem_valid) begin
            if (r_starve_cnt == STARVE_MAX) w_pick_if  = 1'b1;
            else                            w_pick_mem = 1'b1;
          end else if (w_if_valid) begin
            w_pick_if = 1'b1;
          end else if (w_mem_valid) begin
            w_pick_mem = 1'b1;
          end
        end
        if (w_pick_if)       w_next_state = GNT_IF;
        else if (w_pick_mem) w_next_state = GNT_MEM;
      end
      GNT_IF, GNT_MEM: begin
        if (bif.bus_ready)              w_done  = 1'b1;
        else if (r_tmo_cnt == TMO_MAX)  w_abort = 1'b1;
        if (w_done || w_abort) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_starve_cnt  <= '0;
      r_tmo_cnt     <= '0;
      r_if_ack      <= 1'b0;
      r_mem_ack     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_if_rdata    <= '0;
      r_mem_rdata   <= '0;
      r_bus_rd_ctrl <= '0;
      r_bus_wr_ctrl <= '0;
      r_bus_addr    <= '0;
      r_bus_din     <= '0;
    end else begin
      r_state       <= w_next_state;
      r_if_ack      <= 1'b0;
      r_mem_ack     <= 1'b0;
      r_timeout_err <= 1'b0;

      if (w_pick_if) begin
        r_bus_rd_ctrl <= IF_RD_CTRL;
        r_bus_wr_ctrl <= WR_NONE;
        r_bus_addr    <= bif.if_addr;
        r_bus_din     <= '0;
        r_tmo_cnt     <= TW'(1);
        r_starve_cnt  <= '0;
      end else if (w_pick_mem) begin
        r_bus_rd_ctrl <= bif.mem_rd_ctrl;
        r_bus_wr_ctrl <= bif.mem_wr_ctrl;
        r_bus_addr    <= bif.mem_addr;
        r_bus_din     <= bif.mem_wdata;
        r_tmo_cnt     <= TW'(1);
        if (!bif.if_req)                    r_starve_cnt <= '0;
        else if (r_starve_cnt != STARVE_MAX) r_starve_cnt <= r_starve_cnt + SW'(1);
      end else if (r_state == IDLE && !bif.if_req) begin
        r_starve_cnt <= '0;
      end

      // Completion and abort both release the bus; an abort returns zero data.
      if (w_done || w_abort) begin
        r_bus_rd_ctrl <= '0;
        r_bus_wr_ctrl <= '0;
        r_bus_addr    <= '0;
        r_bus_din     <= '0;
        r_timeout_err <= w_abort;
        if (r_state == GNT_IF) begin
          r_if_ack   <= 1'b1;
          r_if_rdata <= w_abort ? 32'd0 : bif.bus_dout[31:0];
        end else begin
          r_mem_ack   <= 1'b1;
          r_mem_rdata <= w_abort ? 64'd0 : bif.bus_dout;
        end
      end else if (r_state != IDLE) begin
        r_tmo_cnt <= r_tmo_cnt + TW'(1);
      end
    end
  end

  assign bif.if_rdata    = r_if_rdata;
  assign bif.if_ack      = r_if_ack;
  assign bif.if_stall    = bif.if_req && !r_if_ack;
  assign bif.mem_rdata   = r_mem_rdata;
  assign bif.mem_ack     = r_mem_ack;
  assign bif.mem_stall   = bif.mem_req && !r_mem_ack;
  assign bif.bus_rd_ctrl = r_bus_rd_ctrl;
  assign bif.bus_wr_ctrl = r_bus_wr_ctrl;
  assign bif.bus_addr    = r_bus_addr;
  assign bif.bus_din     = r_bus_din;
  assign bif.timeout_err = r_timeout_err;
  assign o_state         = r_state;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Directed bench for sys_bus_arbiter: single fetch, conflict, fairness order,
// wait states, timeout and its boundary, and reset mid-transaction.
module tb_sys_bus_arbiter;
  import rvcpu_bus_defs::*;

  logic       clk = 1'b0;
  logic       rst;
  arb_state_e dbg_state;
  int         n_vec = 0;
  int         n_err = 0;
  logic [1:0] exp_q[$];

  sys_bus_arbiter_if bif();

  sys_bus_arbiter #(
    .FAIR_LIMIT(2),
    .TIMEOUT   (16),
    .IF_RD_CTRL(3'b011)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bif    (bif),
    .o_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bif.if_req      = 1'b0;
    bif.if_addr     = '0;
    bif.mem_req     = 1'b0;
    bif.mem_rd_ctrl = '0;
    bif.mem_wr_ctrl = '0;
    bif.mem_addr    = '0;
    bif.mem_wdata   = '0;
    bif.bus_dout    = '0;
    bif.bus_ready   = 1'b0;
  endtask

  task automatic chk_quiet(input string p);
    chk({p, "_state"},  64'(dbg_state),        64'(IDLE));
    chk({p, "_bus_rd"}, 64'(bif.bus_rd_ctrl),  64'd0);
    chk({p, "_bus_wr"}, 64'(bif.bus_wr_ctrl),  64'd0);
    chk({p, "_addr"},   bif.bus_addr,          64'd0);
    chk({p, "_din"},    bif.bus_din,           64'd0);
    chk({p, "_if_ack"}, 64'(bif.if_ack),       64'd0);
    chk({p, "_m_ack"},  64'(bif.mem_ack),      64'd0);
    chk({p, "_tmo"},    64'(bif.timeout_err),  64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("rst");
    chk("rst_if_rdata",  64'(bif.if_rdata), 64'd0);
    chk("rst_mem_rdata", bif.mem_rdata,     64'd0);
    step();
  endtask

  // Zero-wait instruction fetch: request cycle 0, bus cycle 1, ack cycle 2.
  task automatic zw_if(input logic [63:0] addr, input logic [63:0] dout, input logic [31:0] exp_rd);
    bif.if_req  = 1'b1;
    bif.if_addr = addr;
    @(negedge clk);
    chk("if_c0_stall", 64'(bif.if_stall),    64'd1);
    chk("if_c0_state", 64'(dbg_state),       64'(IDLE));
    chk("if_c0_busrd", 64'(bif.bus_rd_ctrl), 64'd0);
    step();
    bif.bus_ready = 1'b1;
    bif.bus_dout  = dout;
    @(negedge clk);
    chk("if_c1_state", 64'(dbg_state),       64'(GNT_IF));
    chk("if_c1_addr",  bif.bus_addr,         addr);
    chk("if_c1_busrd", 64'(bif.bus_rd_ctrl), 64'd3);
    chk("if_c1_buswr", 64'(bif.bus_wr_ctrl), 64'd0);
    chk("if_c1_din",   bif.bus_din,          64'd0);
    chk("if_c1_stall", 64'(bif.if_stall),    64'd1);
    chk("if_c1_ack",   64'(bif.if_ack),      64'd0);
    step();
    bif.bus_ready = 1'b0;
    bif.bus_dout  = ~dout;
    @(negedge clk);
    chk("if_c2_ack",   64'(bif.if_ack),      64'd1);
    chk("if_c2_rdata", 64'(bif.if_rdata),    64'(exp_rd));
    chk("if_c2_stall", 64'(bif.if_stall),    64'd0);
    chk("if_c2_tmo",   64'(bif.timeout_err), 64'd0);
    chk("if_c2_state", 64'(dbg_state),       64'(IDLE));
    chk("if_c2_addr",  bif.bus_addr,         64'd0);
    step();
    bif.if_req = 1'b0;
    @(negedge clk);
    chk("if_c3_ack",   64'(bif.if_ack),      64'd0);
    chk("if_c3_rdata", 64'(bif.if_rdata),    64'(exp_rd));
    chk("if_c3_state", 64'(dbg_state),       64'(IDLE));
    step();
  endtask

  task automatic zw_mem(input logic [2:0] rd, input logic [2:0] wr, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [63:0] dout, input logic [63:0] exp_rd);
    bif.mem_req     = 1'b1;
    bif.mem_rd_ctrl = rd;
    bif.mem_wr_ctrl = wr;
    bif.mem_addr    = addr;
    bif.mem_wdata   = wdata;
    step();
    bif.bus_ready = 1'b1;
    bif.bus_dout  = dout;
    @(negedge clk);
    chk("mem_c1_state", 64'(dbg_state),       64'(GNT_MEM));
    chk("mem_c1_busrd", 64'(bif.bus_rd_ctrl), 64'(rd));
    chk("mem_c1_buswr", 64'(bif.bus_wr_ctrl), 64'(wr));
    chk("mem_c1_addr",  bif.bus_addr,         addr);
    chk("mem_c1_din",   bif.bus_din,          wdata);
    step();
    bif.bus_ready = 1'b0;
    bif.bus_dout  = '0;
    @(negedge clk);
    chk("mem_c2_ack",   64'(bif.mem_ack),     64'd1);
    chk("mem_c2_rdata", bif.mem_rdata,        exp_rd);
    chk("mem_c2_stall", 64'(bif.mem_stall),   64'd0);
    step();
    bif.mem_req     = 1'b0;
    bif.mem_rd_ctrl = '0;
    bif.mem_wr_ctrl = '0;
    step();
  endtask

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    idle_inputs();
    rst = 1'b1;

    // single IF request
    do_reset();
    zw_if(64'h1000, 64'hABCD_0000_0000_0013, 32'h0000_0013);

    // simultaneous requests: MEM first, IF after turnaround
    do_reset();
    bif.if_req      = 1'b1;
    bif.if_addr     = 64'h3000;
    bif.mem_req     = 1'b1;
    bif.mem_rd_ctrl = RD_NONE;
    bif.mem_wr_ctrl = WR_SD;
    bif.mem_addr    = 64'h2000;
    bif.mem_wdata   = 64'hDEAD;
    @(negedge clk);
    chk("sim_c0_istall", 64'(bif.if_stall),  64'd1);
    chk("sim_c0_mstall", 64'(bif.mem_stall), 64'd1);
    step();
    bif.bus_ready = 1'b1;
    @(negedge clk);
    chk("sim_c1_state", 64'(dbg_state),       64'(GNT_MEM));
    chk("sim_c1_buswr", 64'(bif.bus_wr_ctrl), 64'd4);
    chk("sim_c1_busrd", 64'(bif.bus_rd_ctrl), 64'd0);
    chk("sim_c1_addr",  bif.bus_addr,         64'h2000);
    chk("sim_c1_din",   bif.bus_din,          64'hDEAD);
    step();
    bif.bus_ready = 1'b0;
    @(negedge clk);
    chk("sim_c2_mack",   64'(bif.mem_ack),  64'd1);
    chk("sim_c2_state",  64'(dbg_state),    64'(IDLE));
    chk("sim_c2_istall", 64'(bif.if_stall), 64'd1);
    step();
    bif.mem_req     = 1'b0;
    bif.mem_wr_ctrl = '0;
    @(negedge clk);
    chk("sim_c3_state", 64'(dbg_state),   64'(IDLE));
    chk("sim_c3_mack",  64'(bif.mem_ack), 64'd0);
    step();
    bif.bus_ready = 1'b1;
    bif.bus_dout  = 64'h0000_0000_0000_0093;
    @(negedge clk);
    chk("sim_c4_state", 64'(dbg_state),       64'(GNT_IF));
    chk("sim_c4_addr",  bif.bus_addr,         64'h3000);
    chk("sim_c4_busrd", 64'(bif.bus_rd_ctrl), 64'd3);
    step();
    bif.bus_ready = 1'b0;
    @(negedge clk);
    chk("sim_c5_iack",  64'(bif.if_ack),   64'd1);
    chk("sim_c5_rdata", 64'(bif.if_rdata), 64'h93);
    step();
    bif.if_req = 1'b0;
    step();

    // fairness: both held high, zero-wait slave
    do_reset();
    exp_q = '{2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd1};
    bif.if_req      = 1'b1;
    bif.if_addr     = 64'h7000;
    bif.mem_req     = 1'b1;
    bif.mem_rd_ctrl = RD_LW;
    bif.mem_addr    = 64'h8000;
    bif.bus_ready   = 1'b1;
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      if (dbg_state != IDLE) begin
        if (exp_q.size() == 0) chk("fair_extra", 64'(dbg_state), 64'(IDLE));
        else                   chk("fair_grant", 64'(dbg_state), 64'(exp_q.pop_front()));
      end
      step();
    end
    chk("fair_left", 64'(exp_q.size()), 64'd0);
    bif.if_req      = 1'b0;
    bif.mem_req     = 1'b0;
    bif.mem_rd_ctrl = '0;
    step();
    step();
    bif.bus_ready = 1'b0;
    step();

    // wait states: ready after 3 wait cycles on a load
    do_reset();
    bif.mem_req     = 1'b1;
    bif.mem_rd_ctrl = RD_LD;
    bif.mem_addr    = 64'h4000;
    step();
    for (int c = 1; c <= 4; c++) begin
      bif.bus_ready = (c == 4);
      bif.bus_dout  = (c == 4) ? 64'h1122_3344_5566_7788 : 64'hBAD0_BAD0_BAD0_BAD0;
      @(negedge clk);
      chk("ws_state", 64'(dbg_state),       64'(GNT_MEM));
      chk("ws_addr",  bif.bus_addr,         64'h4000);
      chk("ws_busrd", 64'(bif.bus_rd_ctrl), 64'd4);
      chk("ws_ack",   64'(bif.mem_ack),     64'd0);
      step();
    end
    bif.bus_ready = 1'b0;
    bif.bus_dout  = '0;
    @(negedge clk);
    chk("ws_c5_ack",   64'(bif.mem_ack),   64'd1);
    chk("ws_c5_rdata", bif.mem_rdata,      64'h1122_3344_5566_7788);
    chk("ws_c5_addr",  bif.bus_addr,       64'd0);
    chk("ws_c5_stall", 64'(bif.mem_stall), 64'd0);
    step();
    bif.mem_req     = 1'b0;
    bif.mem_rd_ctrl = '0;
    @(negedge clk);
    chk("ws_c6_hold", bif.mem_rdata,    64'h1122_3344_5566_7788);
    chk("ws_c6_ack",  64'(bif.mem_ack), 64'd0);
    step();

    // timeout on a dead slave, then normal service, then the ready-at-limit boundary
    do_reset();
    zw_if(64'h100, 64'h0000_0000_0000_0013, 32'h0000_0013);
    bif.if_req    = 1'b1;
    bif.if_addr   = 64'h5000;
    bif.bus_ready = 1'b0;
    bif.bus_dout  = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      chk("tmo_state", 64'(dbg_state),  64'(GNT_IF));
      chk("tmo_ack",   64'(bif.if_ack), 64'd0);
      step();
    end
    @(negedge clk);
    chk("tmo_c17_ack",   64'(bif.if_ack),      64'd1);
    chk("tmo_c17_rdata", 64'(bif.if_rdata),    64'd0);
    chk("tmo_c17_err",   64'(bif.timeout_err), 64'd1);
    chk("tmo_c17_state", 64'(dbg_state),       64'(IDLE));
    chk("tmo_c17_busrd", 64'(bif.bus_rd_ctrl), 64'd0);
    step();
    bif.if_req   = 1'b0;
    bif.bus_dout = '0;
    @(negedge clk);
    chk("tmo_c18_err", 64'(bif.timeout_err), 64'd0);
    step();
    zw_if(64'h5004, 64'h0000_0000_0000_0033, 32'h0000_0033);
    bif.if_req  = 1'b1;
    bif.if_addr = 64'h5008;
    step();
    for (int c = 1; c <= 16; c++) begin
      bif.bus_ready = (c == 16);
      bif.bus_dout  = 64'h0000_0000_CAFE_F00D;
      @(negedge clk);
      chk("edge_state", 64'(dbg_state), 64'(GNT_IF));
      step();
    end
    bif.bus_ready = 1'b0;
    @(negedge clk);
    chk("edge_ack",   64'(bif.if_ack),      64'd1);
    chk("edge_err",   64'(bif.timeout_err), 64'd0);
    chk("edge_rdata", 64'(bif.if_rdata),    64'hCAFE_F00D);
    step();
    bif.if_req = 1'b0;
    step();

    // reset in the middle of a MEM wait
    do_reset();
    zw_if(64'h6000, 64'h0000_0000_0000_0077, 32'h0000_0077);
    bif.mem_req     = 1'b1;
    bif.mem_rd_ctrl = RD_LW;
    bif.mem_addr    = 64'h9000;
    step();
    @(negedge clk);
    chk("rm_c1_state", 64'(dbg_state), 64'(GNT_MEM));
    step();
    rst = 1'b1;
    step();
    rst             = 1'b0;
    bif.mem_req     = 1'b0;
    bif.mem_rd_ctrl = '0;
    @(negedge clk);
    chk_quiet("rm_c3");
    chk("rm_c3_if_rdata",  64'(bif.if_rdata),  64'd0);
    chk("rm_c3_mem_rdata", bif.mem_rdata,      64'd0);
    chk("rm_c3_mstall",    64'(bif.mem_stall), 64'd0);
    step();
    bif.bus_ready = 1'b1;
    @(negedge clk);
    chk("rm_c4_mack", 64'(bif.mem_ack), 64'd0);
    step();
    bif.bus_ready = 1'b0;
    @(negedge clk);
    chk("rm_c5_mack", 64'(bif.mem_ack), 64'd0);
    step();
    zw_mem(RD_LW, WR_NONE, 64'h9000, 64'd0, 64'h0000_0000_1234_5678, 64'h0000_0000_1234_5678);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sys_bus_arbiter.md
Name: sys_bus_arbiter

Overview:
- Shares the single sys_bus between the IF-stage instruction fetch port and the MEM-stage data port.
- Replaces the combinational address mux in the datapath with a registered grant FSM, a per-port request/ack handshake and stall outputs.
- MEM normally wins a conflict; a starvation counter guarantees IF forward progress; a timeout stops the pipeline hanging on a dead slave.
- Sits between data_path's stage ports and the sys_bus.

Parameters:
- FAIR_LIMIT, 2: consecutive MEM grants with IF waiting, after which IF wins the next conflict; legal range is 1 or more.
- TIMEOUT, 16: cycles in a grant state without bus_ready before the transaction is aborted; legal range is 1 or more.
- IF_RD_CTRL, 3'b011: bus_rd_ctrl code driven for instruction fetches (32-bit word read).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high with if_addr stable until if_ack.
- if_addr  in  64  fetch address.
- if_rdata  out  32  fetched instruction; valid while if_ack is high.
- if_ack  out  1  one-cycle completion pulse.
- if_stall  out  1  if_req && !if_ack.
- mem_req  in  1  data request; held high with payload stable until mem_ack.
- mem_rd_ctrl  in  3  load type; 0 means no read.
- mem_wr_ctrl  in  3  store type; 0 means no write.
- mem_addr  in  64  data address.
- mem_wdata  in  64  store data.
- mem_rdata  out  64  load data; valid while mem_ack is high.
- mem_ack  out  1  one-cycle completion pulse.
- mem_stall  out  1  mem_req && !mem_ack.
- bus_rd_ctrl  out  3  registered, to sys_bus.
- bus_wr_ctrl  out  3  registered, to sys_bus.
- bus_addr  out  64  registered, to sys_bus.
- bus_din  out  64  registered, to sys_bus.
- bus_dout  in  64  read data from sys_bus.
- bus_ready  in  1  slave completion, sampled in grant states.
- timeout_err  out  1  one-cycle pulse alongside the ack of an aborted transaction.

Behaviour:
- Reset: rst is synchronous and active-high.
  - State goes to IDLE; starvation and timeout counters clear.
  - All outputs are 0, including the bus_* outputs and both acks.
  - Reset during a grant state abandons the transaction; no ack is issued.
- States: IDLE, GNT_IF, GNT_MEM.
- IDLE arbitration:
  - A requester whose ack is high in this cycle is ignored for that cycle, so a stale request is never re-granted.
  - The conflict case is both requests valid.
  - In a conflict, MEM wins unless starve_cnt == FAIR_LIMIT, in which case IF wins.
  - With a single valid request, that request is granted.
  - On a grant, the winner's payload is latched into the bus_* registers at the edge and the FSM enters the grant state.
- Bus drive in GNT_IF:
  - bus_rd_ctrl = IF_RD_CTRL, bus_wr_ctrl = 0, bus_addr = if_addr, bus_din = 0.
- Bus drive in GNT_MEM:
  - mem_rd_ctrl, mem_wr_ctrl, mem_addr and mem_wdata pass through as latched.
- Completion:
  - In a grant state, bus_ready high at an edge completes the transaction.
  - On the next cycle: state = IDLE, bus_* return to 0, and the matching ack pulses for one cycle.
  - if_rdata = bus_dout[31:0] captured at that edge; mem_rdata = bus_dout captured at that edge.
  - rdata holds its value until the next completion on that port.
- Latency:
  - Minimum 2 cycles from request to ack: request seen in IDLE at cycle 0, bus driven in cycle 1, bus_ready in cycle 1, ack in cycle 2.
  - Each extra wait cycle adds 1.
  - After an ack there is one idle cycle before the next grant, so back-to-back throughput is one transaction per 3 cycles with a zero-wait slave.
- Starvation counter (saturating at FAIR_LIMIT):
  - Increments when MEM is granted while if_req is high.
  - Clears when IF is granted, or in any IDLE cycle with if_req low.
- Timeout:
  - tmo_cnt counts cycles in a grant state and resets on entering that state.
  - When tmo_cnt reaches TIMEOUT with bus_ready still low, the FSM returns to IDLE.
  - The granted port is acked with rdata = 0 and timeout_err = 1 for that cycle.
  - bus_ready and the timeout in the same cycle count as normal completion, with timeout_err = 0.
- A request dropped before its ack is a protocol violation; the in-flight bus transaction still completes and its ack is still issued.

Decomposition:
- Shared package/header rvcpu_bus_defs holds:
  - the bus_rd_ctrl and bus_wr_ctrl encodings (RD_NONE, RD_LB … RD_LD, WR_NONE, WR_SB … WR_SD);
  - the arbiter state encoding (IDLE=2'd0, GNT_IF=2'd1, GNT_MEM=2'd2).
- One single module. The counters and FSM are too small to justify a sub-module.

Test Plan:
- Single IF request:
  - Stimulus: only if_req, if_addr=0x1000, zero-wait slave returning 0x00000013.
  - Required: bus_addr=0x1000 with bus_rd_ctrl=3'b011 in cycle 1; if_ack with if_rdata=0x13 in cycle 2; if_stall high in cycles 0–1.
- Simultaneous requests:
  - Stimulus: if_req and mem_req in the same cycle, mem store with mem_addr=0x2000 and mem_wdata=0xDEAD, starve_cnt=0.
  - Required: MEM granted first with bus_wr_ctrl = mem_wr_ctrl; mem_ack in cycle 2; IF granted in cycle 3; if_ack in cycle 5.
- Fairness:
  - Stimulus: if_req held high while mem_req is continuously re-asserted, FAIR_LIMIT=2.
  - Required: grant order MEM, MEM, IF, MEM, MEM, IF.
- Wait states:
  - Stimulus: slave asserts bus_ready after 3 wait cycles on a MEM load.
  - Required: mem_ack in cycle 5; bus_* held stable during cycles 1–4; mem_rdata equals bus_dout at the completing edge.
- Timeout:
  - Stimulus: bus_ready never asserted, TIMEOUT=16.
  - Required: ack with rdata=0 and timeout_err=1 exactly 16 cycles after the grant; FSM back in IDLE; next request serviced normally.
- Reset mid-transaction:
  - Stimulus: rst in cycle 2 of a GNT_MEM wait.
  - Required: next cycle state=IDLE and all outputs 0; no mem_ack issued; a request after reset is serviced with the 2-cycle latency.
